// File: rtl/vblank_scheduler.sv
// vblank_scheduler: starts the enabled update engines in index order once per frame at the blanking line,
// with a per-engine timeout and an abort (overrun) if the next frame's first active line arrives first.
module vblank_scheduler #(
    parameter int N_ENG        = 4,
    parameter int TRIGGER_LINE = 480,
    parameter int TIMEOUT      = 50000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [9:0]       pixel_y,
    input  logic [N_ENG-1:0] en_mask,
    input  logic [N_ENG-1:0] done,
    input  logic             clear_err,
    output logic [N_ENG-1:0] start,
    output logic             frame_tick,
    output logic             busy,
    output logic             overrun,
    output logic [N_ENG-1:0] timeout_err,
    output logic [15:0]      frame_cnt
);
    localparam int IW = N_ENG > 1 ? $clog2(N_ENG) : 1;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t state;
    logic [N_ENG-1:0] mask_q;
    logic [IW-1:0] idx, first_idx, next_idx;
    logic first_ok, next_ok, trig_prev, act_prev, trig_hit, act_hit, trig, act;
    logic [15:0] cnt, cnt_next;
    assign trig_hit = pixel_y == 10'(TRIGGER_LINE);
    assign act_hit  = pixel_y == 10'd0;
    assign trig     = trig_hit && !trig_prev;
    assign act      = act_hit && !act_prev;
    assign cnt_next = cnt + 16'd1;
    // Lowest enabled engine for a new window, and the next enabled one above the current engine.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                first_ok  = 1'b1;
                first_idx = IW'(i);
            end
            if (mask_q[i] && i > int'(idx)) begin
                next_ok  = 1'b1;
                next_idx = IW'(i);
            end
        end
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            idx         <= '0;
            cnt         <= '0;
            trig_prev   <= 1'b0;
            act_prev    <= 1'b0;
            start       <= '0;
            frame_tick  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= '0;
            frame_cnt   <= '0;
        end else begin
            trig_prev  <= trig_hit;
            act_prev   <= act_hit;
            start      <= '0;
            frame_tick <= 1'b0;
            if (clear_err) begin
                overrun     <= 1'b0;
                timeout_err <= '0;
            end
            case (state)
                S_IDLE: if (trig) begin
                    mask_q     <= en_mask;
                    frame_tick <= 1'b1;
                    if (first_ok) begin
                        idx   <= first_idx;
                        start <= N_ENG'(1) << first_idx;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
                    end else begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                S_ISSUE: if (act) begin
                    overrun <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end else begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (act) begin
                    overrun <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end else if (done[idx] || cnt_next == 16'(TIMEOUT)) begin
                    if (!done[idx]) timeout_err[idx] <= 1'b1;
                    if (next_ok) begin
                        idx   <= next_idx;
                        start <= N_ENG'(1) << next_idx;
                        state <= S_ISSUE;
                    end else begin
                        frame_cnt <= frame_cnt + 16'd1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end else begin
                    cnt <= cnt_next;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
